// File: rtl/mcause_csr_unit_if.sv
// Bus between the trap arbiter / CSR file and the mcause unit, plus the field mirrors feeding the trace port.
// The master drives the requests and the slave (mcause_csr_unit) drives the responses and mirrors.
interface mcause_csr_unit_if #(
    parameter int XLEN   = 32,
    parameter int CODE_W = 10
);
    logic              trap_valid;
    logic              trap_ready;
    logic              trap_is_irq;
    logic [CODE_W-1:0] trap_code;
    logic              trap_vectored;
    logic              cur_mie;
    logic [1:0]        cur_priv;
    logic [7:0]        cur_il;

    logic              mret_valid;
    logic              ret_valid;
    logic              ret_mie;
    logic [1:0]        ret_priv;
    logic [7:0]        ret_il;
    logic              ret_refetch;

    logic              vec_fetch_done;
    logic              vec_fetch_fault;

    logic              csr_wr_en;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;

    logic [CODE_W-1:0] code;
    logic              interrupt;
    logic [7:0]        mpil;
    logic              mpie;
    logic [1:0]        mpp;
    logic              minhv;

    modport master (
        output trap_valid, trap_is_irq, trap_code, trap_vectored, cur_mie, cur_priv, cur_il,
        output mret_valid, vec_fetch_done, vec_fetch_fault, csr_wr_en, csr_wdata,
        input  trap_ready, ret_valid, ret_mie, ret_priv, ret_il, ret_refetch, csr_rdata,
        input  code, interrupt, mpil, mpie, mpp, minhv
    );

    modport slave (
        input  trap_valid, trap_is_irq, trap_code, trap_vectored, cur_mie, cur_priv, cur_il,
        input  mret_valid, vec_fetch_done, vec_fetch_fault, csr_wr_en, csr_wdata,
        output trap_ready, ret_valid, ret_mie, ret_priv, ret_il, ret_refetch, csr_rdata,
        output code, interrupt, mpil, mpie, mpp, minhv
    );
endinterface

// File: rtl/mcause_csr_unit.sv
// mcause CSR: trap capture, mret restore, WARL CSR writes and CLIC vector-fetch tracking.
// Define MCAUSE_CLIC_EN for the CLIC fields (mpil/minhv/mpie/mpp visible) and the vector-fetch FSM.
module mcause_csr_unit #(
    parameter int XLEN   = 32,
    parameter int CODE_W = 10,
    parameter int PIL_W  = 8,
    parameter int HAS_U  = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    mcause_csr_unit_if.slave csr_bus
);
`ifdef MCAUSE_CLIC_EN
    localparam bit CLIC_EN = 1'b1;
`else
    localparam bit CLIC_EN = 1'b0;
`endif

    localparam logic [7:0] PIL_HI_MASK = 8'(8'hFF << (8 - PIL_W));
    localparam logic [7:0] PIL_LO_MASK = ~PIL_HI_MASK;
    localparam logic [1:0] MPP_AFTER_MRET = (HAS_U != 0) ? 2'b00 : 2'b11;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_VEC_FETCH = 1'b1
    } state_t;

    state_t            r_state, w_state_next;
    logic [CODE_W-1:0] r_code, w_code_next;
    logic              r_interrupt, w_interrupt_next;
    logic [7:0]        r_mpil, w_mpil_next;
    logic              r_mpie, w_mpie_next;
    logic [1:0]        r_mpp, w_mpp_next;
    logic              r_minhv, w_minhv_next;
    logic              r_ret_valid, w_ret_valid_next;
    logic              r_ret_mie, w_ret_mie_next;
    logic [1:0]        r_ret_priv, w_ret_priv_next;
    logic [7:0]        r_ret_il, w_ret_il_next;
    logic              r_ret_refetch, w_ret_refetch_next;

    logic              w_trap_ready;
    logic              w_trap_acc;
    logic              w_mret_acc;
    logic              w_wr_acc;
    logic              w_vec_irq;
    logic [1:0]        w_wr_mpp;
    logic [7:0]        w_mpil_vis;
    logic [XLEN-1:0]   w_rdata;
    logic              w_unused_bits;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_code        <= '0;
            r_interrupt   <= 1'b0;
            r_mpil        <= 8'h00;
            r_mpie        <= 1'b0;
            r_mpp         <= 2'b11;
            r_minhv       <= 1'b0;
            r_ret_valid   <= 1'b0;
            r_ret_mie     <= 1'b0;
            r_ret_priv    <= 2'b00;
            r_ret_il      <= 8'h00;
            r_ret_refetch <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_code        <= w_code_next;
            r_interrupt   <= w_interrupt_next;
            r_mpil        <= w_mpil_next;
            r_mpie        <= w_mpie_next;
            r_mpp         <= w_mpp_next;
            r_minhv       <= w_minhv_next;
            r_ret_valid   <= w_ret_valid_next;
            r_ret_mie     <= w_ret_mie_next;
            r_ret_priv    <= w_ret_priv_next;
            r_ret_il      <= w_ret_il_next;
            r_ret_refetch <= w_ret_refetch_next;
        end
    end

    // Vector-fetch FSM plus field updates; trap beats mret beats CSR write.
    always_comb begin
        w_state_next       = r_state;
        w_code_next        = r_code;
        w_interrupt_next   = r_interrupt;
        w_mpil_next        = r_mpil;
        w_mpie_next        = r_mpie;
        w_mpp_next         = r_mpp;
        w_minhv_next       = r_minhv;
        w_ret_valid_next   = 1'b0;
        w_ret_mie_next     = r_ret_mie;
        w_ret_priv_next    = r_ret_priv;
        w_ret_il_next      = r_ret_il;
        w_ret_refetch_next = r_ret_refetch;

        w_trap_ready = !CLIC_EN || (r_state == ST_IDLE) || !csr_bus.trap_is_irq;
        w_trap_acc   = csr_bus.trap_valid && w_trap_ready;
        w_mret_acc   = csr_bus.mret_valid && !w_trap_acc;
        w_wr_acc     = csr_bus.csr_wr_en && !w_trap_acc && !csr_bus.mret_valid;
        w_vec_irq    = CLIC_EN && csr_bus.trap_is_irq && csr_bus.trap_vectored;

        // Reserved privilege encodings leave mpp untouched.
        w_wr_mpp = r_mpp;
        if (HAS_U == 0) begin
            w_wr_mpp = 2'b11;
        end else if (csr_bus.csr_wdata[29:28] == 2'b00 || csr_bus.csr_wdata[29:28] == 2'b11) begin
            w_wr_mpp = csr_bus.csr_wdata[29:28];
        end

        if (w_trap_acc) begin
            w_code_next      = csr_bus.trap_code;
            w_interrupt_next = csr_bus.trap_is_irq;
            w_mpie_next      = csr_bus.cur_mie;
            w_mpp_next       = (HAS_U != 0) ? csr_bus.cur_priv : 2'b11;
            w_mpil_next      = csr_bus.cur_il & PIL_HI_MASK;
            if (w_vec_irq) begin
                w_minhv_next = 1'b1;
                w_state_next = ST_VEC_FETCH;
            end else begin
                // A fault exception taken mid-fetch must leave minhv set for the handler.
                if (r_state == ST_IDLE) begin
                    w_minhv_next = 1'b0;
                end
                w_state_next = ST_IDLE;
            end
        end else begin
            if (w_mret_acc) begin
                w_ret_valid_next   = 1'b1;
                w_ret_mie_next     = r_mpie;
                w_ret_priv_next    = r_mpp;
                w_ret_il_next      = CLIC_EN ? (r_mpil | PIL_LO_MASK) : 8'h00;
                w_ret_refetch_next = CLIC_EN && r_minhv;
                w_mpie_next        = 1'b1;
                w_mpp_next         = MPP_AFTER_MRET;
            end else if (w_wr_acc) begin
                w_code_next      = csr_bus.csr_wdata[CODE_W-1:0];
                w_interrupt_next = csr_bus.csr_wdata[31];
                if (CLIC_EN) begin
                    w_minhv_next = csr_bus.csr_wdata[30];
                    w_mpp_next   = w_wr_mpp;
                    w_mpie_next  = csr_bus.csr_wdata[27];
                    w_mpil_next  = csr_bus.csr_wdata[23:16] & PIL_HI_MASK;
                end
            end
            if (CLIC_EN && r_state == ST_VEC_FETCH && csr_bus.vec_fetch_done && !csr_bus.vec_fetch_fault) begin
                w_minhv_next = 1'b0;
                w_state_next = ST_IDLE;
            end
        end
    end

    assign w_mpil_vis = CLIC_EN ? (r_mpil | PIL_LO_MASK) : 8'h00;

    always_comb begin
        w_rdata             = '0;
        w_rdata[CODE_W-1:0] = r_code;
        w_rdata[31]         = r_interrupt;
        w_rdata[30]         = CLIC_EN && r_minhv;
        w_rdata[29:28]      = CLIC_EN ? r_mpp : 2'b00;
        w_rdata[27]         = CLIC_EN && r_mpie;
        w_rdata[23:16]      = w_mpil_vis;
    end

    assign csr_bus.trap_ready  = w_trap_ready;
    assign csr_bus.ret_valid   = r_ret_valid;
    assign csr_bus.ret_mie     = r_ret_mie;
    assign csr_bus.ret_priv    = r_ret_priv;
    assign csr_bus.ret_il      = r_ret_il;
    assign csr_bus.ret_refetch = r_ret_refetch;
    assign csr_bus.csr_rdata   = w_rdata;
    assign csr_bus.code        = r_code;
    assign csr_bus.interrupt   = r_interrupt;
    assign csr_bus.mpil        = w_mpil_vis;
    assign csr_bus.mpie        = CLIC_EN && r_mpie;
    assign csr_bus.mpp         = CLIC_EN ? r_mpp : 2'b00;
    assign csr_bus.minhv       = CLIC_EN && r_minhv;

    // Reserved write bits and the CLIC-only inputs are legitimately ignored in some builds.
    assign w_unused_bits = ^{csr_bus.csr_wdata, csr_bus.trap_vectored, csr_bus.vec_fetch_done,
                             csr_bus.vec_fetch_fault, csr_bus.cur_il};
endmodule

// File: tb/tb_mcause_csr_unit.sv
// Scoreboard bench for mcause_csr_unit: each step pushes the expected post-edge state, a monitor pops and compares.
// Expectations follow the MCAUSE_CLIC_EN build selected at compile time.
module tb_mcause_csr_unit;
`ifdef MCAUSE_CLIC_EN
    localparam bit CLIC = 1'b1;
`else
    localparam bit CLIC = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] rd;
        bit          rv;
        bit          rmie;
        logic [1:0]  rpriv;
        logic [7:0]  ril;
        bit          rref;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];

    mcause_csr_unit_if #(.XLEN(32), .CODE_W(10)) bus_if ();

    mcause_csr_unit #(.XLEN(32), .CODE_W(10), .PIL_W(8), .HAS_U(1)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .csr_bus (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input bit irq, input bit minhv, input logic [1:0] mpp,
                                       input bit mpie, input logic [7:0] mpil, input logic [9:0] code);
        logic [31:0] v;
        v     = 32'(code);
        v[31] = irq;
        if (CLIC) begin
            v[30]    = minhv;
            v[29:28] = mpp;
            v[27]    = mpie;
            v[23:16] = mpil;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        bus_if.trap_valid      = 1'b0;
        bus_if.trap_is_irq     = 1'b0;
        bus_if.trap_code       = '0;
        bus_if.trap_vectored   = 1'b0;
        bus_if.cur_mie         = 1'b0;
        bus_if.cur_priv        = 2'b00;
        bus_if.cur_il          = 8'h00;
        bus_if.mret_valid      = 1'b0;
        bus_if.vec_fetch_done  = 1'b0;
        bus_if.vec_fetch_fault = 1'b0;
        bus_if.csr_wr_en       = 1'b0;
        bus_if.csr_wdata       = '0;
    endtask

    task automatic set_trap(input bit irq, input bit vec, input logic [9:0] code,
                            input bit mie, input logic [1:0] priv, input logic [7:0] il);
        bus_if.trap_valid    = 1'b1;
        bus_if.trap_is_irq   = irq;
        bus_if.trap_vectored = vec;
        bus_if.trap_code     = code;
        bus_if.cur_mie       = mie;
        bus_if.cur_priv      = priv;
        bus_if.cur_il        = il;
    endtask

    task automatic check_ready(input string tag, input bit irq, input bit exp);
        bus_if.trap_is_irq = irq;
        #1;
        check(tag, 64'(bus_if.trap_ready), 64'(exp));
    endtask

    // Push what the DUT must show after the coming edge, then move to the next drive point.
    task automatic step(input string tag, input logic [31:0] rd, input bit rv = 1'b0, input bit rmie = 1'b0,
                        input logic [1:0] rpriv = 2'b00, input logic [7:0] ril = 8'h00, input bit rref = 1'b0);
        exp_t e;
        e.tag = tag; e.rd = rd; e.rv = rv; e.rmie = rmie; e.rpriv = rpriv; e.ril = ril; e.rref = rref;
        sb_q.push_back(e);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        exp_t        e;
        logic [31:0] rd;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e  = sb_q.pop_front();
                rd = e.rd;
                $display("txn %s rdata=%08h ret_valid=%0b ret_il=%02h ret_priv=%0d", e.tag,
                         bus_if.csr_rdata, bus_if.ret_valid, bus_if.ret_il, bus_if.ret_priv);
                check({e.tag, ".rdata"}, 64'(bus_if.csr_rdata), 64'(rd));
                check({e.tag, ".code"}, 64'(bus_if.code), 64'(rd[9:0]));
                check({e.tag, ".minhv"}, 64'(bus_if.minhv), 64'(rd[30]));
                check({e.tag, ".ret_valid"}, 64'(bus_if.ret_valid), 64'(e.rv));
                if (e.rv) begin
                    check({e.tag, ".ret_mie"}, 64'(bus_if.ret_mie), 64'(e.rmie));
                    check({e.tag, ".ret_priv"}, 64'(bus_if.ret_priv), 64'(e.rpriv));
                    check({e.tag, ".ret_il"}, 64'(bus_if.ret_il), 64'(e.ril));
                    check({e.tag, ".ret_refetch"}, 64'(bus_if.ret_refetch), 64'(e.rref));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle_inputs();
        step("reset1", mk(0, 0, 2'b11, 0, 8'h00, 0));
        step("reset2", mk(0, 0, 2'b11, 0, 8'h00, 0));
        rst = 1'b0;
        check_ready("ready_after_reset", 1'b1, 1'b1);

        set_trap(0, 0, 10'd5, 1, 2'b00, 8'h00);
        check_ready("ready_exc", 1'b0, 1'b1);
        step("exc5", mk(0, 0, 2'b00, 1, 8'h00, 5));

        set_trap(1, 1, 10'd11, 0, 2'b11, 8'h40);
        step("virq11", mk(1, 1, 2'b11, 0, 8'h40, 11));

        set_trap(1, 0, 10'd3, 1, 2'b00, 8'h00);
        bus_if.trap_valid = CLIC;
        check_ready("ready_held_off", 1'b1, !CLIC);
        step("irq_holdoff", mk(1, 1, 2'b11, 0, 8'h40, 11));

        check_ready("ready_exc_in_fetch", 1'b0, 1'b1);
        bus_if.vec_fetch_done = 1'b1;
        step("fetch_ok", mk(1, 0, 2'b11, 0, 8'h40, 11));
        check_ready("ready_after_fetch", 1'b1, 1'b1);

        bus_if.mret_valid = 1'b1;
        step("mret1", mk(1, 0, 2'b00, 1, 8'h40, 11), 1'b1, 1'b0, 2'b11, CLIC ? 8'h40 : 8'h00, 1'b0);
        step("idle1", mk(1, 0, 2'b00, 1, 8'h40, 11));

        set_trap(1, 1, 10'd7, 1, 2'b11, 8'h80);
        step("virq7", mk(1, 1, 2'b11, 1, 8'h80, 7));
        bus_if.vec_fetch_done  = 1'b1;
        bus_if.vec_fetch_fault = 1'b1;
        step("fetch_fault", mk(1, 1, 2'b11, 1, 8'h80, 7));
        check_ready("ready_after_fault", 1'b1, !CLIC);

        set_trap(0, 0, 10'd1, 0, 2'b00, 8'h20);
        step("fault_exc1", mk(0, 1, 2'b00, 0, 8'h20, 1));
        check_ready("ready_after_fault_exc", 1'b1, 1'b1);

        bus_if.mret_valid = 1'b1;
        step("mret2", mk(0, 1, 2'b00, 1, 8'h20, 1), 1'b1, 1'b0, 2'b00, CLIC ? 8'h20 : 8'h00, CLIC);

        bus_if.csr_wr_en = 1'b1;
        bus_if.csr_wdata = 32'hB75A_FC2A;
        step("wr_fields", mk(1, 0, 2'b11, 0, 8'h5A, 10'h02A));
        bus_if.csr_wr_en = 1'b1;
        bus_if.csr_wdata = 32'h6F00_0003;
        step("wr_mpp10", mk(0, 1, 2'b11, 1, 8'h00, 3));

        set_trap(0, 0, 10'd9, 1, 2'b00, 8'h10);
        bus_if.mret_valid = 1'b1;
        bus_if.csr_wr_en  = 1'b1;
        bus_if.csr_wdata  = 32'hFFFF_FFFF;
        step("trap_mret_wr", mk(0, 0, 2'b00, 1, 8'h10, 9));

        bus_if.mret_valid = 1'b1;
        bus_if.csr_wr_en  = 1'b1;
        bus_if.csr_wdata  = 32'hFFFF_FFFF;
        step("mret_wr", mk(0, 0, 2'b00, 1, 8'h10, 9), 1'b1, 1'b1, 2'b00, CLIC ? 8'h10 : 8'h00, 1'b0);

        bus_if.csr_wr_en = 1'b1;
        bus_if.csr_wdata = 32'h0000_0000;
        step("wr_zero", mk(0, 0, 2'b00, 0, 8'h00, 0));

        set_trap(1, 1, 10'd2, 1, 2'b11, 8'hC0);
        step("virq2", mk(1, 1, 2'b11, 1, 8'hC0, 2));
        check_ready("ready_before_reset", 1'b1, !CLIC);
        rst = 1'b1;
        step("reset_mid_fetch", mk(0, 0, 2'b11, 0, 8'h00, 0));
        rst = 1'b0;
        check_ready("ready_after_mid_reset", 1'b1, 1'b1);
        step("idle_end", mk(0, 0, 2'b11, 0, 8'h00, 0));

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
